// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

   localparam int WORD_ADDR_W = 30;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_ACCESS = 1'b1
   } arb_state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_t;

   // Stores acknowledge with zero data; loads return what memory delivered.
   function automatic logic [31:0] mask_load_data(input logic [3:0] we, input logic [31:0] rdata);
      logic [31:0] res;
      if (we != 4'd0) begin
         res = 32'd0;
      end else begin
         res = rdata;
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_arb_lat_ctr.sv
// Loadable down-counter that times one memory access; last flags the final cycle.
module mem_arb_lat_ctr #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         last
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load takes precedence; otherwise count down toward zero while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one fixed-latency memory port.
// Data normally wins; a starvation counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants taken while fetch was waiting.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_req,
   input  logic [WORD_ADDR_W-1:0] if_addr,
   output logic                   if_gnt,
   output logic                   if_rvalid,
   output logic [31:0]            if_rdata,
   output logic                   if_excpt,
   input  logic                   d_req,
   input  logic [WORD_ADDR_W-1:0] d_addr,
   input  logic [3:0]             d_we,
   input  logic [31:0]            d_wdata,
   output logic                   d_gnt,
   output logic                   d_rvalid,
   output logic [31:0]            d_rdata,
   output logic                   d_excpt,
   output logic                   m_en,
   output logic [WORD_ADDR_W-1:0] m_addr,
   output logic [3:0]             m_we,
   output logic [31:0]            m_wdata,
   input  logic [31:0]            m_rdata,
   input  logic                   m_excpt
);

   localparam int LW = $clog2(MEM_LATENCY + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LATENCY);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_t             state_q, state_d;
   req_id_t                id_q, id_d;
   logic [WORD_ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]             we_q, we_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [SW-1:0]          starve_cnt_q, starve_cnt_d;
   logic                   if_rvalid_q, if_rvalid_d;
   logic                   d_rvalid_q, d_rvalid_d;
   logic [31:0]            if_rdata_q, if_rdata_d;
   logic [31:0]            d_rdata_q, d_rdata_d;
   logic                   if_excpt_q, if_excpt_d;
   logic                   d_excpt_q, d_excpt_d;

   logic                   if_gnt_s;
   logic                   d_gnt_s;
   logic                   lat_load_s;
   logic                   lat_en_s;
   logic [LW-1:0]          lat_cnt_s;
   logic                   lat_last_s;

   assign lat_en_s = (state_q == ARB_ACCESS) && (lat_cnt_s != '0);

   mem_arb_lat_ctr #(.W(LW)) u_lat_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (lat_load_s),
      .load_val (LAT_LOAD),
      .en       (lat_en_s),
      .cnt      (lat_cnt_s),
      .last     (lat_last_s)
   );

   // Grant decision in IDLE: data first unless fetch has been starved long enough.
   always_comb begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
      if (state_q == ARB_IDLE) begin
         if (d_req && if_req) begin
            if (starve_cnt_q == STARVE_MAX) begin
               if_gnt_s = 1'b1;
            end else begin
               d_gnt_s = 1'b1;
            end
         end else if (d_req) begin
            d_gnt_s = 1'b1;
         end else if (if_req) begin
            if_gnt_s = 1'b1;
         end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
         end
      end else begin
         if_gnt_s = 1'b0;
         d_gnt_s  = 1'b0;
      end
   end

   // Next-state: latch the winner at grant, capture the response on the last access cycle.
   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      starve_cnt_d = starve_cnt_q;
      if_rvalid_d  = 1'b0;
      d_rvalid_d   = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_excpt_d   = if_excpt_q;
      d_excpt_d    = d_excpt_q;
      lat_load_s   = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (d_gnt_s) begin
               state_d    = ARB_ACCESS;
               lat_load_s = 1'b1;
               id_d       = REQ_D;
               addr_d     = d_addr;
               we_d       = d_we;
               wdata_d    = d_wdata;
               if (!if_req) begin
                  starve_cnt_d = '0;
               end else if (starve_cnt_q == STARVE_MAX) begin
                  starve_cnt_d = starve_cnt_q;
               end else begin
                  starve_cnt_d = starve_cnt_q + SW'(1);
               end
            end else if (if_gnt_s) begin
               state_d      = ARB_ACCESS;
               lat_load_s   = 1'b1;
               id_d         = REQ_IF;
               addr_d       = if_addr;
               we_d         = 4'd0;
               wdata_d      = 32'd0;
               starve_cnt_d = '0;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_ACCESS: begin
            if (lat_last_s) begin
               state_d = ARB_IDLE;
               if (id_q == REQ_IF) begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = m_rdata;
                  if_excpt_d  = m_excpt;
               end else begin
                  d_rvalid_d = 1'b1;
                  d_rdata_d  = mask_load_data(we_q, m_rdata);
                  d_excpt_d  = m_excpt;
               end
            end else begin
               state_d = ARB_ACCESS;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State, latch and response registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         id_q         <= REQ_IF;
         addr_q       <= '0;
         we_q         <= 4'd0;
         wdata_q      <= 32'd0;
         starve_cnt_q <= '0;
         if_rvalid_q  <= 1'b0;
         d_rvalid_q   <= 1'b0;
         if_rdata_q   <= 32'd0;
         d_rdata_q    <= 32'd0;
         if_excpt_q   <= 1'b0;
         d_excpt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         starve_cnt_q <= starve_cnt_d;
         if_rvalid_q  <= if_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_excpt_q   <= if_excpt_d;
         d_excpt_q    <= d_excpt_d;
      end
   end

   // Memory port is quiet outside ACCESS so nothing can be written while idle.
   assign m_en    = (state_q == ARB_ACCESS);
   assign m_addr  = m_en ? addr_q  : '0;
   assign m_we    = m_en ? we_q    : 4'd0;
   assign m_wdata = m_en ? wdata_q : 32'd0;

   assign if_gnt    = if_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign if_excpt  = if_excpt_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign d_excpt   = d_excpt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset, directed vectors,
// multi-cycle corner sequences and a randomized run against a cycle-schedule model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int LAT  = 2;
   localparam int SLIM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [29:0] if_addr = 30'd0;
   logic        if_gnt, if_rvalid, if_excpt;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic [29:0] d_addr = 30'd0;
   logic [3:0]  d_we = 4'd0;
   logic [31:0] d_wdata = 32'd0;
   logic        d_gnt, d_rvalid, d_excpt;
   logic [31:0] d_rdata;
   logic        m_en;
   logic [29:0] m_addr;
   logic [3:0]  m_we;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = 32'd0;
   logic        m_excpt = 1'b0;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_excpt(if_excpt),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_excpt(d_excpt),
      .m_en(m_en), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_excpt(m_excpt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- memory environment ----------------
   logic [31:0] env_mem [logic [29:0]];
   logic [31:0] wtmp;

   function automatic logic [31:0] init_word(input logic [29:0] a);
      return {a, 2'b01} ^ 32'h5a5a_0000;
   endfunction

   function automatic logic is_fault(input logic [29:0] a);
      return (a[29:28] == 2'b11);
   endfunction

   // Memory answers combinationally-in-cycle: update after each edge once m_* settle.
   always begin
      @(posedge clk);
      #2;
      if (m_en && (m_we != 4'd0)) begin
         wtmp = env_mem.exists(m_addr) ? env_mem[m_addr] : init_word(m_addr);
         for (int b = 0; b < 4; b++) begin
            if (m_we[b]) wtmp[8*b +: 8] = m_wdata[8*b +: 8];
         end
         env_mem[m_addr] = wtmp;
      end
      if (m_en) begin
         m_rdata = env_mem.exists(m_addr) ? env_mem[m_addr] : init_word(m_addr);
         m_excpt = is_fault(m_addr);
      end else begin
         m_rdata = 32'd0;
         m_excpt = 1'b0;
      end
   end

   // Invariants that must hold every cycle.
   always @(negedge clk) begin
      if (!m_en) check("m_we_idle", 32'(m_we), 32'd0);
      check("rvalid_excl", 32'(if_rvalid & d_rvalid), 32'd0);
      check("gnt_excl", 32'(if_gnt & d_gnt), 32'd0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        is_d;
      logic [29:0] addr;
      logic [3:0]  we;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        ex;
   } vec_t;

   vec_t vecs [8];
   logic last_if_ex = 1'b0;
   logic last_d_ex  = 1'b0;

   task automatic do_access(input vec_t v, input int idx);
      int   n;
      logic got;
      if (v.is_d) begin
         d_req = 1'b1; d_addr = v.addr; d_we = v.we; d_wdata = v.wd;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      got = 1'b0;
      n   = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         got = v.is_d ? d_gnt : if_gnt;
         if (!got) begin
            @(posedge clk); #1;
         end
         n++;
      end
      check($sformatf("vec%0d_gnt", idx), 32'(got), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;
      if_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wd; d_we = 4'd0;
      if (got) begin
         for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            check($sformatf("vec%0d_m_en", idx), 32'(m_en), 32'd1);
            check($sformatf("vec%0d_m_addr", idx), 32'(m_addr), 32'(v.addr));
            check($sformatf("vec%0d_m_we", idx), 32'(m_we), v.is_d ? 32'(v.we) : 32'd0);
            check($sformatf("vec%0d_m_wdata", idx), m_wdata, v.is_d ? v.wd : 32'd0);
            check($sformatf("vec%0d_early_rvalid", idx), 32'(if_rvalid | d_rvalid), 32'd0);
            @(posedge clk); #1;
         end
         @(negedge clk);
         check($sformatf("vec%0d_if_rvalid", idx), 32'(if_rvalid), 32'(!v.is_d));
         check($sformatf("vec%0d_d_rvalid", idx), 32'(d_rvalid), 32'(v.is_d));
         if (v.is_d) begin
            check($sformatf("vec%0d_d_rdata", idx), d_rdata, v.rd);
            check($sformatf("vec%0d_d_excpt", idx), 32'(d_excpt), 32'(v.ex));
            check($sformatf("vec%0d_if_excpt_hold", idx), 32'(if_excpt), 32'(last_if_ex));
            last_d_ex = v.ex;
         end else begin
            check($sformatf("vec%0d_if_rdata", idx), if_rdata, v.rd);
            check($sformatf("vec%0d_if_excpt", idx), 32'(if_excpt), 32'(v.ex));
            check($sformatf("vec%0d_d_excpt_hold", idx), 32'(d_excpt), 32'(last_d_ex));
            last_if_ex = v.ex;
         end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- reference model for the random run ----------------
   logic [31:0] mdl_mem [logic [29:0]];

   function automatic logic [31:0] mdl_rd(input logic [29:0] a);
      return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
   endfunction

   function automatic logic [29:0] rnd_addr();
      logic [29:0] a;
      a = 30'(32'h0000_0020 + 32'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) a = a | 30'h3000_0000;
      return a;
   endfunction

   int          gseq [$];
   int          exp_pat [6];
   logic        chk_starve;
   int          bound;
   int          rv_count;
   logic        last_rv;
   int          free_at, acc_s, acc_e, resp_at, starve;
   logic        resp_d, resp_ex, e_ig, e_dg, if_won, d_won;
   logic [31:0] resp_rd, acc_wd, mw;
   logic [29:0] acc_a;
   logic [3:0]  acc_we;

   initial begin
      exp_pat = '{1, 1, 1, 1, 0, 1};
      vecs[0] = '{1'b0, 30'h0010_0000, 4'h0, 32'h0,          32'h2402_000a, 1'b0};
      vecs[1] = '{1'b1, 30'h0000_4000, 4'h0, 32'h0,          32'hdead_beef, 1'b0};
      vecs[2] = '{1'b1, 30'h0000_4000, 4'h3, 32'h1234_5678,  32'h0,         1'b0};
      vecs[3] = '{1'b1, 30'h0000_4000, 4'h0, 32'h0,          32'hdead_5678, 1'b0};
      vecs[4] = '{1'b1, 30'h3000_0010, 4'h0, 32'h0,          32'h9a5a_0041, 1'b1};
      vecs[5] = '{1'b0, 30'h3000_0020, 4'h0, 32'h0,          32'h9a5a_0081, 1'b1};
      vecs[6] = '{1'b0, 30'h0000_4000, 4'h0, 32'h0,          32'hdead_5678, 1'b0};
      vecs[7] = '{1'b1, 30'h3000_0030, 4'hf, 32'h0bad_0bad,  32'h0,         1'b1};
      env_mem[30'h0010_0000] = 32'h2402_000a;

      // Reset values.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_if_gnt", 32'(if_gnt), 32'd0);
      check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_if_excpt", 32'(if_excpt), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_d_excpt", 32'(d_excpt), 32'd0);
      check("rst_m_en", 32'(m_en), 32'd0);
      check("rst_m_addr", 32'(m_addr), 32'd0);
      check("rst_m_we", 32'(m_we), 32'd0);
      check("rst_m_wdata", m_wdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_m_en", 32'(m_en), 32'd0);
         @(posedge clk); #1;
      end

      // Store, then a load to the same word granted in the store's response cycle.
      d_req = 1'b1; d_addr = 30'h0000_4000; d_we = 4'hf; d_wdata = 32'hdead_beef;
      @(negedge clk);
      check("sl_store_gnt", 32'(d_gnt), 32'd1);
      @(posedge clk); #1;
      d_req = 1'b0; d_wdata = 32'd0; d_we = 4'd0;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         check("sl_store_m_en", 32'(m_en), 32'd1);
         check("sl_store_m_we", 32'(m_we), 32'hf);
         check("sl_store_m_wdata", m_wdata, 32'hdead_beef);
         @(posedge clk); #1;
      end
      d_req = 1'b1; d_we = 4'd0;
      @(negedge clk);
      check("sl_store_rvalid", 32'(d_rvalid), 32'd1);
      check("sl_store_rdata", d_rdata, 32'd0);
      check("sl_load_gnt", 32'(d_gnt), 32'd1);
      check("sl_mem_written", env_mem.exists(30'h0000_4000) ? env_mem[30'h0000_4000] : 32'd0, 32'hdead_beef);
      @(posedge clk); #1;
      d_req = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         check("sl_load_wait", 32'(d_rvalid), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("sl_load_rvalid", 32'(d_rvalid), 32'd1);
      check("sl_load_rdata", d_rdata, 32'hdead_beef);
      @(posedge clk); #1;

      // Table-driven single accesses.
      for (int i = 0; i < 8; i++) do_access(vecs[i], i);

      // Priority and starvation with both requests held.
      if_req = 1'b1; if_addr = 30'h0000_0200;
      d_req = 1'b1; d_addr = 30'h0000_0300; d_we = 4'd0;
      chk_starve = 1'b0;
      bound = 0;
      while (gseq.size() < 6 && bound < 60) begin
         @(negedge clk);
         if (d_gnt) gseq.push_back(1);
         if (if_gnt) begin
            gseq.push_back(0);
            chk_starve = 1'b1;
         end
         @(posedge clk); #1;
         if (chk_starve) begin
            check("starve_clear", 32'(dut.starve_cnt_q), 32'd0);
            chk_starve = 1'b0;
         end
         bound++;
      end
      if_req = 1'b0; d_req = 1'b0;
      check("starve_grant_count", 32'(gseq.size()), 32'd6);
      for (int i = 0; i < gseq.size() && i < 6; i++) begin
         check($sformatf("starve_grant%0d_is_data", i), 32'(gseq[i]), 32'(exp_pat[i]));
      end
      repeat (LAT + 2) @(posedge clk);
      #1;

      // Reset in the first ACCESS cycle of a fetch.
      if_req = 1'b1; if_addr = 30'h0000_0500;
      @(negedge clk);
      check("rm_gnt", 32'(if_gnt), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rm_m_en", 32'(m_en), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      if_req = 1'b1; if_addr = 30'h0000_0600;
      rv_count = 0;
      @(negedge clk);
      check("rm_regnt", 32'(if_gnt), 32'd1);
      if (if_rvalid) rv_count++;
      @(posedge clk); #1;
      if_req = 1'b0;
      last_rv = 1'b0;
      for (int k = 0; k < LAT + 1; k++) begin
         @(negedge clk);
         if (if_rvalid) rv_count++;
         last_rv = if_rvalid;
         @(posedge clk); #1;
      end
      check("rm_single_rvalid", 32'(rv_count), 32'd1);
      check("rm_rvalid_timing", 32'(last_rv), 32'd1);
      repeat (2) @(posedge clk);
      #1;

      // Randomized run against a cycle-schedule model.
      foreach (env_mem[a]) mdl_mem[a] = env_mem[a];
      free_at = 0; acc_s = -1; acc_e = -2; resp_at = -1; starve = 0;
      resp_d = 1'b0; resp_rd = 32'd0; resp_ex = 1'b0;
      acc_a = 30'd0; acc_we = 4'd0; acc_wd = 32'd0;
      if_won = 1'b0; d_won = 1'b0;
      for (int t = 0; t < 400; t++) begin
         if (!if_req || if_won) begin
            if_req = ($urandom_range(0, 2) != 0);
            if_addr = rnd_addr();
         end
         if (!d_req || d_won) begin
            d_req = ($urandom_range(0, 2) != 0);
            d_addr = rnd_addr();
            d_we = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            d_wdata = $urandom;
         end
         e_ig = 1'b0; e_dg = 1'b0;
         if (t >= free_at) begin
            if (d_req && (!if_req || starve < SLIM)) e_dg = 1'b1;
            else if (if_req) e_ig = 1'b1;
         end
         @(negedge clk);
         check($sformatf("rnd%0d_if_gnt", t), 32'(if_gnt), 32'(e_ig));
         check($sformatf("rnd%0d_d_gnt", t), 32'(d_gnt), 32'(e_dg));
         check($sformatf("rnd%0d_m_en", t), 32'(m_en), 32'(t >= acc_s && t <= acc_e));
         if (t >= acc_s && t <= acc_e) begin
            check($sformatf("rnd%0d_m_addr", t), 32'(m_addr), 32'(acc_a));
            check($sformatf("rnd%0d_m_we", t), 32'(m_we), 32'(acc_we));
            check($sformatf("rnd%0d_m_wdata", t), m_wdata, acc_wd);
         end
         check($sformatf("rnd%0d_if_rvalid", t), 32'(if_rvalid), 32'(t == resp_at && !resp_d));
         check($sformatf("rnd%0d_d_rvalid", t), 32'(d_rvalid), 32'(t == resp_at && resp_d));
         if (t == resp_at) begin
            check($sformatf("rnd%0d_rdata", t), resp_d ? d_rdata : if_rdata, resp_rd);
            check($sformatf("rnd%0d_excpt", t), 32'(resp_d ? d_excpt : if_excpt), 32'(resp_ex));
         end
         if (e_dg || e_ig) begin
            acc_s = t + 1; acc_e = t + LAT; free_at = t + LAT + 1; resp_at = t + LAT + 1;
            resp_d = e_dg;
            acc_a  = e_dg ? d_addr : if_addr;
            acc_we = e_dg ? d_we : 4'd0;
            acc_wd = e_dg ? d_wdata : 32'd0;
            resp_ex = is_fault(acc_a);
            if (acc_we != 4'd0) begin
               mw = mdl_rd(acc_a);
               for (int b = 0; b < 4; b++) begin
                  if (acc_we[b]) mw[8*b +: 8] = acc_wd[8*b +: 8];
               end
               mdl_mem[acc_a] = mw;
               resp_rd = 32'd0;
            end else begin
               resp_rd = mdl_rd(acc_a);
            end
            if (e_ig) starve = 0;
            else if (!if_req) starve = 0;
            else if (starve < SLIM) starve = starve + 1;
         end
         if_won = if_gnt;
         d_won  = d_gnt;
         @(posedge clk); #1;
      end
      if_req = 1'b0; d_req = 1'b0;
      repeat (LAT + 2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
